// File: rtl/alu_nibble_seq_if.sv
// Bus bundle for the nibble-serial ALU sequencer: controller handshake,
// operands, result/flags and the external 4-bit adder path.
// The use_carry signal exists only when ALU_SEQ_ADC_EN is defined.
interface alu_nibble_seq_if;
  logic       start;
  logic       sub;
`ifdef ALU_SEQ_ADC_EN
  logic       use_carry;
`endif
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_s;
  logic       add_cout;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       flag_c;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;

`ifdef ALU_SEQ_ADC_EN
  // Controller plus external adder side.
  modport master (
    output start, sub, use_carry, op_a, op_b, add_s, add_cout,
    input  add_a, add_b, add_cin, busy, done, result, flag_c, flag_z, flag_n, flag_v
  );
  // Sequencer side.
  modport slave (
    input  start, sub, use_carry, op_a, op_b, add_s, add_cout,
    output add_a, add_b, add_cin, busy, done, result, flag_c, flag_z, flag_n, flag_v
  );
`else
  // Controller plus external adder side.
  modport master (
    output start, sub, op_a, op_b, add_s, add_cout,
    input  add_a, add_b, add_cin, busy, done, result, flag_c, flag_z, flag_n, flag_v
  );
  // Sequencer side.
  modport slave (
    input  start, sub, op_a, op_b, add_s, add_cout,
    output add_a, add_b, add_cin, busy, done, result, flag_c, flag_z, flag_n, flag_v
  );
`endif
endinterface

// File: rtl/alu_nibble_seq.sv
// Nibble-serial 8-bit add/subtract sequencer driving an external 4-bit adder
// twice (low nibble, then high nibble) and latching result and C/Z/N/V flags.
// Optional feature macro: ALU_SEQ_ADC_EN (stored carry chains into cin for ADC/SBC).
module alu_nibble_seq (
  input logic          clk,
  input logic          reset,
  alu_nibble_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q;
  logic [7:0] b_q;      // operand B already inverted for subtract
  logic       cin0_q;
  logic [3:0] lo_q;
  logic       c4_q;
  logic [7:0] result_q;
  logic       flag_c_q, flag_z_q, flag_n_q, flag_v_q;

  logic       accept;
  logic       cin0;
  logic [7:0] result_new;

  assign accept     = bus.start && ((state_q == StIdle) || (state_q == StDone));
  assign result_new = {bus.add_s, lo_q};

`ifdef ALU_SEQ_ADC_EN
  assign cin0 = bus.use_carry ? flag_c_q : bus.sub;
`else
  assign cin0 = bus.sub;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is ignored while an operation is in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = bus.start ? StLo : StIdle;
      StLo:    state_d = StHi;
      StHi:    state_d = StDone;
      StDone:  state_d = bus.start ? StLo : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Adder drive and handshake outputs, zero outside the two passes.
  always_comb begin
    bus.add_a   = 4'h0;
    bus.add_b   = 4'h0;
    bus.add_cin = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    unique case (state_q)
      StLo: begin
        bus.add_a   = a_q[3:0];
        bus.add_b   = b_q[3:0];
        bus.add_cin = cin0_q;
        bus.busy    = 1'b1;
      end
      StHi: begin
        bus.add_a   = a_q[7:4];
        bus.add_b   = b_q[7:4];
        bus.add_cin = c4_q;
        bus.busy    = 1'b1;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, inter-pass carry, and result/flag commit at HI->DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      cin0_q   <= 1'b0;
      lo_q     <= 4'h0;
      c4_q     <= 1'b0;
      result_q <= 8'h00;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= bus.op_a;
        b_q    <= bus.sub ? ~bus.op_b : bus.op_b;
        cin0_q <= cin0;
      end
      if (state_q == StLo) begin
        lo_q <= bus.add_s;
        c4_q <= bus.add_cout;
      end
      if (state_q == StHi) begin
        result_q <= result_new;
        flag_c_q <= bus.add_cout;
        flag_z_q <= (result_new == 8'h00);
        flag_n_q <= result_new[7];
        flag_v_q <= (a_q[7] == b_q[7]) && (result_new[7] != a_q[7]);
      end
    end
  end

  assign bus.result = result_q;
  assign bus.flag_c = flag_c_q;
  assign bus.flag_z = flag_z_q;
  assign bus.flag_n = flag_n_q;
  assign bus.flag_v = flag_v_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: directed vectors plus random
// operations checked against a whole-byte arithmetic reference model.
module tb_alu_nibble_seq;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   done_cnt;

`ifdef ALU_SEQ_ADC_EN
  localparam bit AdcEn = 1'b1;
`else
  localparam bit AdcEn = 1'b0;
`endif

  alu_nibble_seq_if bus ();

  alu_nibble_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External 4-bit adder (adder_283 behaviour).
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'h0, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  // Reference-model state: last committed result and flags {C,Z,N,V}.
  logic [7:0] m_res;
  logic [3:0] m_flags;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, {7'h0, bus.busy}, 8'h00);
    chk({tag, " done"}, {7'h0, bus.done}, 8'h00);
    chk({tag, " adder"}, {bus.add_a, bus.add_b[2:0], bus.add_cin}, 8'h00);
  endtask

  // Starts at a negedge in IDLE/DONE, ends at the negedge of the DONE cycle.
  // noise keeps start asserted with garbage operands during LO and HI.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input bit s, input bit uc,
                    input bit noise);
    logic [7:0] beff;
    logic       cin;
    int         sum;
    int         ssum;
    logic       lo_c;
    logic [7:0] r;
    logic [3:0] f;
    beff = s ? ~b : b;
    cin  = (AdcEn && uc) ? m_flags[3] : s;
    sum  = int'(a) + int'(beff) + int'(cin);
    ssum = int'($signed(a)) + int'($signed(beff)) + int'(cin);
    lo_c = ((int'(a[3:0]) + int'(beff[3:0]) + int'(cin)) > 15);
    r    = sum[7:0];
    f    = {sum > 255, r == 8'h00, r[7], (ssum > 127) || (ssum < -128)};

    bus.start = 1'b1;
    bus.sub   = s;
    bus.op_a  = a;
    bus.op_b  = b;
`ifdef ALU_SEQ_ADC_EN
    bus.use_carry = uc;
`endif
    @(posedge clk);
    @(negedge clk);
    // LO pass
    chk("lo busy", {7'h0, bus.busy}, 8'h01);
    chk("lo done", {7'h0, bus.done}, 8'h00);
    chk("lo add_a", {4'h0, bus.add_a}, {4'h0, a[3:0]});
    chk("lo add_b", {4'h0, bus.add_b}, {4'h0, beff[3:0]});
    chk("lo add_cin", {7'h0, bus.add_cin}, {7'h0, cin});
    chk("lo result hold", bus.result, m_res);
    if (noise) begin
      bus.start = 1'b1;
      bus.op_a  = ~a;
      bus.op_b  = a ^ b;
      bus.sub   = ~s;
    end else begin
      bus.start = 1'b0;
    end
    @(negedge clk);
    // HI pass
    chk("hi busy", {7'h0, bus.busy}, 8'h01);
    chk("hi add_a", {4'h0, bus.add_a}, {4'h0, a[7:4]});
    chk("hi add_b", {4'h0, bus.add_b}, {4'h0, beff[7:4]});
    chk("hi add_cin", {7'h0, bus.add_cin}, {7'h0, lo_c});
    chk("hi flags hold", {4'h0, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v},
        {4'h0, m_flags});
    @(negedge clk);
    // DONE
    bus.start = 1'b0;
    m_res   = r;
    m_flags = f;
    chk("done pulse", {7'h0, bus.done}, 8'h01);
    chk("done busy", {7'h0, bus.busy}, 8'h00);
    chk("result", bus.result, r);
    chk("flags CZNV", {4'h0, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, {4'h0, f});
  endtask

  initial begin
    int         base;
    logic [7:0] ra, rb;
    n_chk     = 0;
    n_fail    = 0;
    done_cnt  = 0;
    m_res     = 8'h00;
    m_flags   = 4'h0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = 8'h00;
    bus.op_b  = 8'h00;
`ifdef ALU_SEQ_ADC_EN
    bus.use_carry = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_idle("reset");
    chk("reset result", bus.result, 8'h00);
    chk("reset flags", {4'h0, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 8'h00);
    @(negedge clk);

    // Directed vectors.
    op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_idle("after first");
    op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    op(8'h05, 8'h05, 1'b1, 1'b0, 1'b0);
    op(8'h03, 8'h05, 1'b1, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // start pulsed during LO and HI is ignored: exactly one done pulse.
    base = done_cnt;
    op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_idle("noise idle");
    @(negedge clk);
    chk("noise done count", 8'(done_cnt - base), 8'h01);

    // start held continuously: back-to-back operations every 3 cycles.
    base = done_cnt;
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    @(negedge clk);
    chk("held done count", 8'(done_cnt - base), 8'h04);

    // Random operations, some back-to-back, some with idle gaps.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    // Carry chain: with ADC enabled the stored carry feeds the next operation.
    op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    op(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("chain result", bus.result, AdcEn ? 8'h01 : 8'h00);
    @(negedge clk);

    // Reset during HI aborts without a done pulse and clears state.
    op(8'h40, 8'h02, 1'b0, 1'b0, 1'b0);
    chk("pre-abort result", bus.result, 8'h42);
    @(negedge clk);
    base      = done_cnt;
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.op_a  = 8'h11;
    bus.op_b  = 8'h22;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort in hi", {7'h0, bus.busy}, 8'h01);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    m_res   = 8'h00;
    m_flags = 4'h0;
    chk_idle("abort");
    chk("abort result", bus.result, 8'h00);
    chk("abort flags", {4'h0, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 8'h00);
    @(negedge clk);
    chk_idle("abort later");
    chk("abort done count", 8'(done_cnt - base), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
